// File: rtl/mat_ata_gram.sv
// Gram matrix G = A^T A of a 3x3 signed fixed-point matrix using one shared
// multiply-accumulate unit. The six unique entries of the symmetric result are
// computed in 18 MAC cycles and presented together, level-held, with o_Dval.
module mat_ata_gram #(
    parameter int unsigned ZOOM = 6
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               i_start,
    input  logic signed [32:0] i_mat00,
    input  logic signed [32:0] i_mat01,
    input  logic signed [32:0] i_mat02,
    input  logic signed [32:0] i_mat10,
    input  logic signed [32:0] i_mat11,
    input  logic signed [32:0] i_mat12,
    input  logic signed [32:0] i_mat20,
    input  logic signed [32:0] i_mat21,
    input  logic signed [32:0] i_mat22,
    output logic signed [32:0] o_mat00,
    output logic signed [32:0] o_mat01,
    output logic signed [32:0] o_mat02,
    output logic signed [32:0] o_mat10,
    output logic signed [32:0] o_mat11,
    output logic signed [32:0] o_mat12,
    output logic signed [32:0] o_mat20,
    output logic signed [32:0] o_mat21,
    output logic signed [32:0] o_mat22,
    output logic               o_busy,
    output logic               o_Dval
);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDone
    } state_e;

    localparam logic signed [67:0] SatMax = 68'sd4294967295;
    localparam logic signed [67:0] SatMin = -68'sd4294967296;

    state_e             state_q, state_d;
    logic signed [32:0] a_q   [9];
    logic signed [32:0] a_d   [9];
    logic signed [32:0] g_q   [9];
    logic signed [32:0] g_d   [9];
    logic signed [32:0] o_q   [9];
    logic signed [32:0] o_d   [9];
    logic signed [32:0] a_in  [9];
    logic signed [67:0] acc_q, acc_d;
    logic [2:0]         e_q, e_d;
    logic [1:0]         k_q, k_d;
    logic               busy_q, busy_d;
    logic               dval_q, dval_d;

    // Datapath operands and results
    logic [1:0]         col_i, col_j;
    logic [3:0]         idx_ki, idx_kj, idx_ij, idx_ji;
    logic signed [32:0] op_a, op_b;
    logic signed [65:0] prod;
    logic signed [67:0] acc_base;
    logic signed [67:0] sum;
    logic signed [67:0] shifted;
    logic signed [32:0] res;

    // Row-major packing of the input matrix
    always_comb begin
        a_in[0] = i_mat00;
        a_in[1] = i_mat01;
        a_in[2] = i_mat02;
        a_in[3] = i_mat10;
        a_in[4] = i_mat11;
        a_in[5] = i_mat12;
        a_in[6] = i_mat20;
        a_in[7] = i_mat21;
        a_in[8] = i_mat22;
    end

    // Entry order (0,0),(0,1),(0,2),(1,1),(1,2),(2,2) mapped to (i,j)
    always_comb begin
        col_i = 2'd0;
        col_j = 2'd0;
        unique case (e_q)
            3'd0:    begin col_i = 2'd0; col_j = 2'd0; end
            3'd1:    begin col_i = 2'd0; col_j = 2'd1; end
            3'd2:    begin col_i = 2'd0; col_j = 2'd2; end
            3'd3:    begin col_i = 2'd1; col_j = 2'd1; end
            3'd4:    begin col_i = 2'd1; col_j = 2'd2; end
            3'd5:    begin col_i = 2'd2; col_j = 2'd2; end
            default: begin col_i = 2'd0; col_j = 2'd0; end
        endcase
    end

    // One MAC step: A[k][i]*A[k][j] added to the running sum, then floor-shift and clamp
    always_comb begin
        idx_ki   = 4'(k_q) * 4'd3 + 4'(col_i);
        idx_kj   = 4'(k_q) * 4'd3 + 4'(col_j);
        idx_ij   = 4'(col_i) * 4'd3 + 4'(col_j);
        idx_ji   = 4'(col_j) * 4'd3 + 4'(col_i);
        op_a     = a_q[idx_ki];
        op_b     = a_q[idx_kj];
        prod     = op_a * op_b;
        acc_base = (k_q == 2'd0) ? '0 : acc_q;
        sum      = acc_base + {{2{prod[65]}}, prod};
        shifted  = sum >>> ZOOM;
        if (shifted > SatMax) begin
            res = SatMax[32:0];
        end else if (shifted < SatMin) begin
            res = SatMin[32:0];
        end else begin
            res = shifted[32:0];
        end
    end

    // Next-state: accept in IDLE/DONE, sequence entries in MAC, publish G on the last step
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        g_d     = g_q;
        o_d     = o_q;
        acc_d   = acc_q;
        e_d     = e_q;
        k_d     = k_q;
        busy_d  = busy_q;
        dval_d  = dval_q;
        case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    a_d     = a_in;
                    e_d     = 3'd0;
                    k_d     = 2'd0;
                    dval_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = sum;
                if (k_q == 2'd2) begin
                    g_d[idx_ij] = res;
                    g_d[idx_ji] = res;
                    k_d         = 2'd0;
                    e_d         = e_q + 3'd1;
                    if (e_q == 3'd5) begin
                        // g_d already holds the entry written this cycle
                        o_d     = g_d;
                        dval_d  = 1'b1;
                        busy_d  = 1'b0;
                        e_d     = 3'd0;
                        state_d = StDone;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any computation and clears the outputs at once
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            e_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            dval_q  <= 1'b0;
            for (int n = 0; n < 9; n++) begin
                a_q[n] <= '0;
                g_q[n] <= '0;
                o_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            e_q     <= e_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            dval_q  <= dval_d;
            for (int n = 0; n < 9; n++) begin
                a_q[n] <= a_d[n];
                g_q[n] <= g_d[n];
                o_q[n] <= o_d[n];
            end
        end
    end

    assign o_mat00 = o_q[0];
    assign o_mat01 = o_q[1];
    assign o_mat02 = o_q[2];
    assign o_mat10 = o_q[3];
    assign o_mat11 = o_q[4];
    assign o_mat12 = o_q[5];
    assign o_mat20 = o_q[6];
    assign o_mat21 = o_q[7];
    assign o_mat22 = o_q[8];
    assign o_busy  = busy_q;
    assign o_Dval  = dval_q;

endmodule

// File: tb/tb_mat_ata_gram.sv
// Directed bench for mat_ata_gram: hand-computed Gram matrices, latency, busy
// window, saturation, ignored mid-run start, DONE restart and async reset abort.
module tb_mat_ata_gram;

    typedef logic [32:0] mat_t [9];

    logic        iclk;
    logic        ireset;
    logic        i_start;
    logic [32:0] a_m [9];
    logic [32:0] o_m [9];
    logic        o_busy;
    logic        o_Dval;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;

    mat_t m_zero, m_ident, m_gen, g_gen, m_floor, g_floor;
    mat_t m_satp, m_satn, g_sat, m_new, g_new;

    mat_ata_gram #(.ZOOM(6)) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .i_start (i_start),
        .i_mat00 (a_m[0]),
        .i_mat01 (a_m[1]),
        .i_mat02 (a_m[2]),
        .i_mat10 (a_m[3]),
        .i_mat11 (a_m[4]),
        .i_mat12 (a_m[5]),
        .i_mat20 (a_m[6]),
        .i_mat21 (a_m[7]),
        .i_mat22 (a_m[8]),
        .o_mat00 (o_m[0]),
        .o_mat01 (o_m[1]),
        .o_mat02 (o_m[2]),
        .o_mat10 (o_m[3]),
        .o_mat11 (o_m[4]),
        .o_mat12 (o_m[5]),
        .o_mat20 (o_m[6]),
        .o_mat21 (o_m[7]),
        .o_mat22 (o_m[8]),
        .o_busy  (o_busy),
        .o_Dval  (o_Dval)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_g(input string tag, input mat_t exp);
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("%s[%0d%0d]", tag, n / 3, n % 3), o_m[n], exp[n]);
        end
    endtask

    task automatic set_a(input mat_t m);
        for (int n = 0; n < 9; n++) a_m[n] = m[n];
    endtask

    // Pulse i_start for one edge; returns at the negedge right after the accepting edge
    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge iclk);
        i_start = 1'b0;
    endtask

    // Count negedges until o_Dval, plus how many of them saw o_busy; bounded
    task automatic run_to_done(output int l, output int b);
        l = 0;
        b = 0;
        while (!o_Dval && l < 40) begin
            if (o_busy) b++;
            @(negedge iclk);
            l++;
        end
    endtask

    initial begin
        m_zero  = '{default: 33'd0};
        m_ident = '{64, 0, 0, 0, 64, 0, 0, 0, 64};
        m_gen   = '{64, 64, 0, 0, 64, 0, 0, 0, 64};
        g_gen   = '{64, 64, 0, 64, 128, 0, 0, 0, 64};
        m_floor = '{1, 33'h1_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0};
        g_floor = '{0, 33'h1_FFFF_FFFF, 0, 33'h1_FFFF_FFFF, 0, 0, 0, 0, 0};
        m_satp  = '{default: 33'h0_8000_0000};
        m_satn  = '{default: 33'h1_8000_0000};
        g_sat   = '{default: 33'h0_FFFF_FFFF};
        // rows [128,0,-64],[64,64,0],[0,0,0]
        m_new   = '{128, 0, 33'h1_FFFF_FFC0, 64, 64, 0, 0, 0, 0};
        g_new   = '{320, 64, 33'h1_FFFF_FF80, 64, 64, 0, 33'h1_FFFF_FF80, 0, 64};

        ireset  = 1'b0;
        i_start = 1'b0;
        set_a(m_zero);

        // Reset state
        repeat (2) @(negedge iclk);
        check_g("rst", m_zero);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_dval", o_Dval, 1'b0);
        ireset = 1'b1;
        @(negedge iclk);

        // Identity: latency and busy window
        set_a(m_ident);
        pulse_start();
        set_a(m_gen);
        run_to_done(lat, bcnt);
        chk("id_latency", 33'(lat), 33'd18);
        chk("id_busy_cycles", 33'(bcnt), 33'd18);
        chk("id_busy_low", o_busy, 1'b0);
        check_g("ident", m_ident);
        repeat (5) @(negedge iclk);
        chk("id_dval_hold", o_Dval, 1'b1);
        check_g("ident_hold", m_ident);

        // General matrix, with an ignored start pulse at MAC cycle 5
        set_a(m_gen);
        pulse_start();
        repeat (4) @(negedge iclk);
        set_a(m_ident);
        i_start = 1'b1;
        @(negedge iclk);
        i_start = 1'b0;
        run_to_done(lat, bcnt);
        chk("gen_latency_rest", 33'(lat), 33'd13);
        check_g("gen", g_gen);

        // Restart from DONE with a new matrix
        set_a(m_new);
        pulse_start();
        chk("restart_dval_drop", o_Dval, 1'b0);
        chk("restart_busy", o_busy, 1'b1);
        check_g("restart_old_held", g_gen);
        set_a(m_zero);
        run_to_done(lat, bcnt);
        chk("new_latency", 33'(lat), 33'd18);
        check_g("new", g_new);

        // Floor on negative products
        set_a(m_floor);
        pulse_start();
        run_to_done(lat, bcnt);
        chk("floor_latency", 33'(lat), 33'd18);
        check_g("floor", g_floor);

        // Saturation, positive and negative inputs
        set_a(m_satp);
        pulse_start();
        run_to_done(lat, bcnt);
        check_g("satp", g_sat);
        set_a(m_satn);
        pulse_start();
        run_to_done(lat, bcnt);
        check_g("satn", g_sat);

        // Async reset at MAC cycle 9
        set_a(m_gen);
        pulse_start();
        repeat (8) @(negedge iclk);
        #2 ireset = 1'b0;
        #1;
        check_g("abort", m_zero);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_dval", o_Dval, 1'b0);
        @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        chk("post_rst_dval", o_Dval, 1'b0);
        set_a(m_floor);
        pulse_start();
        run_to_done(lat, bcnt);
        chk("post_rst_latency", 33'(lat), 33'd18);
        check_g("post_rst", g_floor);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
